// File: rtl/fetch_buffer_if.sv
// rtl/fetch_buffer_if.sv - instruction memory and fetch-output handshake bundle
interface fetch_buffer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_inst;

    // master is the fetch unit, slave is memory plus the IF/ID register
    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_pc_plus4, out_inst,
        input  imem_ready, imem_rvalid, imem_rdata, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_pc_plus4, out_inst,
        output imem_ready, imem_rvalid, imem_rdata, out_ready
    );
endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - fetch PC sequencer with single-outstanding imem port and in-order instruction FIFO
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    fetch_buffer_if.master           bus,
    output logic [$clog2(DEPTH):0]   buf_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          drop;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic          outstanding;
    logic [CW:0]   occupied;
    logic          credit;
    logic          credit_after;
    logic          push;
    logic          pop;
    logic          unused_bits;

    assign unused_bits  = ^redirect_pc[1:0];

    assign outstanding  = (state == S_WAIT);
    assign occupied     = {1'b0, count} + {{CW{1'b0}}, outstanding};
    assign credit       = start && !redirect_valid && (occupied < DEPTH_C);

    assign push         = (state == S_WAIT) && bus.imem_rvalid && !drop && !redirect_valid;
    assign pop          = bus.out_valid && bus.out_ready && !redirect_valid;
    assign count_next   = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    // Re-issue decision in WAIT looks at the occupancy after this cycle's push/pop
    assign credit_after = start && !redirect_valid && ({1'b0, count_next} < DEPTH_C);

    assign bus.imem_req     = (state == S_REQ) && credit;
    assign bus.imem_addr    = fetch_pc;
    assign bus.out_valid    = start && (count != '0);
    assign bus.out_pc       = bus.out_valid ? pc_mem[rd_ptr] : 32'h0;
    assign bus.out_pc_plus4 = bus.out_valid ? pc_mem[rd_ptr] + 32'd4 : 32'h0;
    assign bus.out_inst     = bus.out_valid ? inst_mem[rd_ptr] : 32'h0;
    assign buf_count        = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            drop     <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            // A response landing in the redirect cycle is simply discarded, nothing left to drop
            if (state == S_WAIT && !bus.imem_rvalid) begin
                state <= S_WAIT;
                drop  <= 1'b1;
            end else begin
                state <= S_IDLE;
                drop  <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (credit) state <= S_REQ;
                end
                S_REQ: begin
                    if (!credit) begin
                        state <= S_IDLE;
                    end else if (bus.imem_ready) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        drop  <= 1'b0;
                        state <= credit_after ? S_REQ : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= req_pc;
            inst_mem[wr_ptr] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - directed scoreboard bench for fetch_buffer
module tb_fetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  buf_count;

    fetch_buffer_if bus();

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .buf_count      (buf_count)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          pops;
    int          snap;
    logic        ok;
    logic [63:0] sb[$];
    logic [31:0] exp_pc, pend_pc, last_acc, last_pop_pc;
    logic        mem_pend, stale, exp_drop, rsp_en;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00A0_0113;
            32'h8:   return 32'h0020_81B3;
            default: return 32'h1300_0000 ^ a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic settle();
        bus.imem_ready  = 1'b1;
        bus.imem_rvalid = mem_pend && rsp_en;
        bus.imem_rdata  = bus.imem_rvalid ? mem_word(pend_pc) : 32'h0;
        #1;
    endtask

    task automatic model();
        logic [63:0] h;
        if (!reset_n) begin
            sb.delete();
            if (bus.imem_rvalid) begin
                mem_pend = 1'b0;
                stale    = 1'b0;
            end else if (mem_pend) begin
                stale = 1'b1;
            end
            exp_pc   = RESET_PC;
            exp_drop = 1'b0;
            return;
        end
        chk("buf_count", 32'(buf_count), 32'(sb.size()));
        chk1("out_valid", bus.out_valid, start && sb.size() != 0);
        if (!start || redirect_valid || (sb.size() + int'(mem_pend)) >= DEPTH)
            chk1("req_blocked", bus.imem_req, 1'b0);
        if (!redirect_valid && bus.out_valid && bus.out_ready && sb.size() != 0) begin
            h = sb.pop_front();
            chk("out_pc", bus.out_pc, h[63:32]);
            chk("out_pc_plus4", bus.out_pc_plus4, h[63:32] + 32'd4);
            chk("out_inst", bus.out_inst, h[31:0]);
            pops++;
            last_pop_pc = h[63:32];
        end
        if (bus.imem_rvalid) begin
            mem_pend = 1'b0;
            if (!(redirect_valid || exp_drop || stale))
                sb.push_back({pend_pc, mem_word(pend_pc)});
            exp_drop = 1'b0;
            stale    = 1'b0;
        end
        if (redirect_valid) begin
            sb.delete();
            exp_pc = {redirect_pc[31:2], 2'b00};
            if (mem_pend) exp_drop = 1'b1;
        end
        if (bus.imem_req && bus.imem_ready) begin
            chk("req_addr", bus.imem_addr, exp_pc);
            mem_pend = 1'b1;
            pend_pc  = exp_pc;
            last_acc = exp_pc;
            exp_pc   = exp_pc + 32'd4;
        end
    endtask

    task automatic adv();
        model();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        bus.out_ready  = 1'b0;
        rsp_en         = 1'b1;
        cyc();
        cyc();
        mem_pend = 1'b0;
        stale    = 1'b0;
        last_acc = '1;
        pops     = 0;
    endtask

    task automatic wait_pops(input int n, input string tag);
        for (int i = 0; i < 40 && pops < n; i++) cyc();
        chk(tag, 32'(pops), 32'(n));
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        bus.out_ready = 1'b0; bus.imem_ready = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        rsp_en = 1'b1; mem_pend = 1'b0; stale = 1'b0; exp_drop = 1'b0; exp_pc = RESET_PC;
        pend_pc = 32'h0; last_acc = '1; last_pop_pc = 32'h0; pops = 0;
        @(posedge clk); #2;
        cyc();
        settle();
        chk1("rst_imem_req", bus.imem_req, 1'b0);
        chk("rst_imem_addr", bus.imem_addr, RESET_PC);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_pc_plus4", bus.out_pc_plus4, 32'h0);
        chk("rst_out_inst", bus.out_inst, 32'h0);
        chk("rst_buf_count", 32'(buf_count), 32'h0);
        adv();

        // basic in-order fetch of three instructions
        reset_n = 1'b1; start = 1'b1; bus.out_ready = 1'b1;
        settle(); chk1("first_req_t0", bus.imem_req, 1'b0); adv();
        settle(); chk1("first_req_t1", bus.imem_req, 1'b1); chk("first_addr", bus.imem_addr, RESET_PC); adv();
        wait_pops(3, "t1_pops");
        chk("t1_last_pc", last_pop_pc, 32'h8);

        // fill with consumer stalled, then drain
        do_reset(); reset_n = 1'b1; start = 1'b1;
        repeat (12) cyc();
        settle();
        chk("t2_full_count", 32'(buf_count), 32'd4);
        chk1("t2_full_noreq", bus.imem_req, 1'b0);
        chk("t2_head_pc", bus.out_pc, 32'h0);
        chk("t2_head_inst", bus.out_inst, 32'h0050_0093);
        adv();
        repeat (3) begin settle(); chk1("t2_req_idle", bus.imem_req, 1'b0); adv(); end
        bus.out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (bus.imem_req) begin ok = 1'b1; break; end
            adv();
        end
        chk1("t2_resume_req", ok, 1'b1);
        chk("t2_resume_addr", bus.imem_addr, 32'h10);
        adv();
        wait_pops(4, "t2_drain");
        chk("t2_last_pc", last_pop_pc, 32'hC);

        // redirect while 0x8 is outstanding
        do_reset(); reset_n = 1'b1; start = 1'b1; bus.out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin cyc(); if (last_acc == 32'h8 && mem_pend) begin ok = 1'b1; break; end end
        chk1("t3_reach_wait8", ok, 1'b1);
        rsp_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
        settle(); chk1("t3_req_forced0", bus.imem_req, 1'b0); adv();
        redirect_valid = 1'b0;
        settle(); chk("t3_count0", 32'(buf_count), 32'h0); chk1("t3_no_req", bus.imem_req, 1'b0); adv();
        rsp_en = 1'b1; cyc();
        settle(); chk1("t3_req", bus.imem_req, 1'b1); chk("t3_addr", bus.imem_addr, 32'h100); adv();
        snap = pops;
        wait_pops(snap + 1, "t3_pop");
        chk("t3_first_pc", last_pop_pc, 32'h100);

        // simultaneous push and pop at count 2
        do_reset(); reset_n = 1'b1; start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin cyc(); if (buf_count == 3'd2 && mem_pend) begin ok = 1'b1; break; end end
        chk1("t4_reach", ok, 1'b1);
        bus.out_ready = 1'b1;
        settle(); chk("t4_pre_count", 32'(buf_count), 32'd2); chk("t4_pre_pc", bus.out_pc, 32'h0); adv();
        bus.out_ready = 1'b0;
        settle();
        chk("t4_count", 32'(buf_count), 32'd2);
        chk("t4_head_pc", bus.out_pc, 32'h4);
        chk("t4_head_inst", bus.out_inst, 32'h00A0_0113);
        adv();

        // reset during WAIT, late response afterwards
        do_reset(); reset_n = 1'b1; start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin cyc(); if (last_acc == 32'h8 && mem_pend) begin ok = 1'b1; break; end end
        chk1("t5_reach_wait8", ok, 1'b1);
        rsp_en = 1'b0; reset_n = 1'b0;
        settle();
        chk1("t5_imem_req", bus.imem_req, 1'b0);
        chk("t5_imem_addr", bus.imem_addr, RESET_PC);
        chk1("t5_out_valid", bus.out_valid, 1'b0);
        chk("t5_out_pc", bus.out_pc, 32'h0);
        chk("t5_out_pc_plus4", bus.out_pc_plus4, 32'h0);
        chk("t5_out_inst", bus.out_inst, 32'h0);
        chk("t5_buf_count", 32'(buf_count), 32'h0);
        adv(); cyc();
        reset_n = 1'b1; start = 1'b0; rsp_en = 1'b1; pops = 0;
        cyc();
        settle(); chk("t5_late_ignored", 32'(buf_count), 32'h0); adv();
        start = 1'b1;
        settle(); chk1("t5_idle_req", bus.imem_req, 1'b0); adv();
        settle(); chk1("t5_restart_req", bus.imem_req, 1'b1); chk("t5_restart_addr", bus.imem_addr, RESET_PC); adv();
        bus.out_ready = 1'b1;
        wait_pops(2, "t5_pops");
        chk("t5_last_pc", last_pop_pc, 32'h4);

        // start dropped with three buffered and one outstanding
        do_reset(); reset_n = 1'b1; start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin cyc(); if (buf_count == 3'd3 && mem_pend) begin ok = 1'b1; break; end end
        chk1("t6_reach", ok, 1'b1);
        start = 1'b0;
        settle(); chk1("t6_out_valid", bus.out_valid, 1'b0); chk1("t6_req", bus.imem_req, 1'b0); adv();
        settle(); chk("t6_count", 32'(buf_count), 32'd4); adv();
        repeat (3) begin settle(); chk1("t6_no_req", bus.imem_req, 1'b0); adv(); end
        start = 1'b1; bus.out_ready = 1'b1;
        wait_pops(4, "t6_drain");
        chk("t6_last_pc", last_pop_pc, 32'hC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
